// File: rtl/reg_file.sv
// ============================================================================
//  Module   : reg_file
//  Brief    : 32 x 64-bit RISC-V integer register file, 2 comb. read ports,
//             1 sync. write port with built-in ALU/load write-back mux.
//             Optional macro REGFILE_BYPASS_EN adds same-cycle write-through.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ADDR_WIDTH-1:0] i_ReadReg1,
    input  logic [ADDR_WIDTH-1:0] i_ReadReg2,
    input  logic [ADDR_WIDTH-1:0] i_WriteReg,
    input  logic                  i_MemToReg,
    input  logic                  i_RegWrite,
    input  logic [DATA_WIDTH-1:0] i_ALUresult,
    input  logic [DATA_WIDTH-1:0] i_ReadData,
    output logic [DATA_WIDTH-1:0] o_Data1,
    output logic [DATA_WIDTH-1:0] o_Data2
);

    localparam int C_NREGS = 1 << ADDR_WIDTH;

    // x0 is hard-wired to zero, so storage starts at x1.
    logic [DATA_WIDTH-1:0] regs_q [1:C_NREGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:C_NREGS-1];
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_wr_en;

    assign w_wdata = i_MemToReg ? i_ReadData : i_ALUresult;
    assign w_wr_en = i_RegWrite && (i_WriteReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (w_wr_en) begin
            regs_d[i_WriteReg] = w_wdata;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 1; i < C_NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        o_Data1 = '0;
        o_Data2 = '0;
        if (i_ReadReg1 != '0) begin
            o_Data1 = regs_q[i_ReadReg1];
        end
        if (i_ReadReg2 != '0) begin
            o_Data2 = regs_q[i_ReadReg2];
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through: forward the value being written this cycle.
        if (w_wr_en && !i_Reset && (i_ReadReg1 == i_WriteReg)) begin
            o_Data1 = w_wdata;
        end
        if (w_wr_en && !i_Reset && (i_ReadReg2 == i_WriteReg)) begin
            o_Data2 = w_wdata;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module   : tb_reg_file
//  Brief    : Directed self-checking bench for reg_file.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    logic        i_Clock;
    logic        i_Reset;
    logic [4:0]  i_ReadReg1;
    logic [4:0]  i_ReadReg2;
    logic [4:0]  i_WriteReg;
    logic        i_MemToReg;
    logic        i_RegWrite;
    logic [63:0] i_ALUresult;
    logic [63:0] i_ReadData;
    logic [63:0] o_Data1;
    logic [63:0] o_Data2;

    int tests;
    int fails;

    reg_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_ReadReg1 (i_ReadReg1),
        .i_ReadReg2 (i_ReadReg2),
        .i_WriteReg (i_WriteReg),
        .i_MemToReg (i_MemToReg),
        .i_RegWrite (i_RegWrite),
        .i_ALUresult(i_ALUresult),
        .i_ReadData (i_ReadData),
        .o_Data1    (o_Data1),
        .o_Data2    (o_Data2)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        i_ReadReg1 = r1;
        i_ReadReg2 = r2;
        #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        i_Reset     = 1'b1;
        i_ReadReg1  = '0;
        i_ReadReg2  = '0;
        i_WriteReg  = '0;
        i_MemToReg  = 1'b0;
        i_RegWrite  = 1'b0;
        i_ALUresult = '0;
        i_ReadData  = '0;

        tick();
        i_Reset = 1'b0;
        rd(5'd0, 5'd1);
        check("rst_x0_p1", o_Data1, 64'h0);
        check("rst_x1_p2", o_Data2, 64'h0);
        rd(5'd31, 5'd31);
        check("rst_x31_p1", o_Data1, 64'h0);
        check("rst_x31_p2", o_Data2, 64'h0);

        // Write to x0 must be discarded.
        i_RegWrite  = 1'b1;
        i_WriteReg  = 5'd0;
        i_ALUresult = 64'hFFFF;
        tick();
        rd(5'd0, 5'd0);
        check("x0_protect", o_Data1, 64'h0);

        // x1 = 0xFFFF via ALU path
        i_WriteReg = 5'd1;
        tick();
        rd(5'd1, 5'd1);
        check("x1_p1", o_Data1, 64'hFFFF);
        check("x1_p2", o_Data2, 64'hFFFF);

        // Same-cycle read of x2 while it is being written
        i_WriteReg = 5'd2;
        rd(5'd2, 5'd2);
`ifdef REGFILE_BYPASS_EN
        check("rdw_x2_p1", o_Data1, 64'hFFFF);
        check("rdw_x2_p2", o_Data2, 64'hFFFF);
`else
        check("rdw_x2_p1", o_Data1, 64'h0);
        check("rdw_x2_p2", o_Data2, 64'h0);
`endif
        tick();
        check("x2_p1", o_Data1, 64'hFFFF);
        check("x2_p2", o_Data2, 64'hFFFF);

        i_WriteReg  = 5'd1;
        i_ALUresult = 64'hAFFFF;
        tick();
        rd(5'd1, 5'd2);
        check("x1_new_p1", o_Data1, 64'hAFFFF);
        check("x2_kept_p2", o_Data2, 64'hFFFF);

        // Memory write-back selects i_ReadData
        i_MemToReg  = 1'b1;
        i_ReadData  = 64'h1234_5678_9ABC_DEF0;
        i_ALUresult = 64'hFFFF;
        i_WriteReg  = 5'd5;
        tick();
        i_RegWrite = 1'b0;
        i_MemToReg = 1'b0;
        rd(5'd5, 5'd5);
        check("x5_mem_p1", o_Data1, 64'h1234_5678_9ABC_DEF0);
        check("x5_mem_p2", o_Data2, 64'h1234_5678_9ABC_DEF0);

        // Enable low: nothing changes
        i_WriteReg  = 5'd1;
        i_ALUresult = 64'hDEAD;
        rd(5'd1, 5'd1);
        check("wen0_same_cycle", o_Data1, 64'hAFFFF);
        tick();
        check("wen0_x1", o_Data1, 64'hAFFFF);

        // Reset wins over a simultaneous write
        i_Reset     = 1'b1;
        i_RegWrite  = 1'b1;
        i_WriteReg  = 5'd3;
        i_ALUresult = 64'h55;
        rd(5'd3, 5'd3);
        check("rst_bypass_x3", o_Data1, 64'h0);
        tick();
        i_Reset    = 1'b0;
        i_RegWrite = 1'b0;
        rd(5'd1, 5'd2);
        check("midrst_x1", o_Data1, 64'h0);
        check("midrst_x2", o_Data2, 64'h0);
        rd(5'd3, 5'd5);
        check("midrst_x3", o_Data1, 64'h0);
        check("midrst_x5", o_Data2, 64'h0);

        // Write on the first edge after reset deasserts
        i_RegWrite  = 1'b1;
        i_WriteReg  = 5'd31;
        i_ALUresult = 64'h8000_0000_0000_0077;
        tick();
        i_RegWrite = 1'b0;
        rd(5'd31, 5'd30);
        check("post_rst_x31", o_Data1, 64'h8000_0000_0000_0077);
        check("post_rst_x30", o_Data2, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
